sump_host_link: RTL
===================

Name: sump_host_link

Overview:
- Host-side end of the SUMP serial command link: serializes 1- or 5-byte SUMP commands onto a UART tx line and collects the device's little-endian response bytes from rx into a 32-bit word.
- Used as an on-chip command initiator for loopback and self-test, and as a synthesizable bench driver for the analyzer's serial front end.
- Half-duplex: transmit the command, then listen; bytes arriving during transmission are ignored.

Parameters:
- FREQ, 100000000: clock frequency in Hz.
- RATE, 115200: baud rate. Derived localparam BITLENGTH = FREQ/RATE, in cycles per bit.
- TIMEOUT_BITS, 40: idle bit-times allowed before the response is abandoned.

Ports:
- clock  in  1  system clock.
- extReset  in  1  asynchronous, active-low reset.
- cmd  in  40  {data[31:0], opcode[7:0]}, same layout as the analyzer command bus.
- cmd_valid  in  1  request to send cmd.
- resp_len  in  3  expected response bytes, 0..4; values >4 are clamped to 4. Sampled with cmd.
- cmd_ready  out  1  high in IDLE only.
- busy  out  1  high from command accept until the resp_valid cycle inclusive.
- tx  out  1  UART line, idle high.
- rx  in  1  UART line from device, asynchronous; double-flop synchronized internally.
- resp_data  out  32  response word; byte k lands in [8k+7:8k]; unreceived bytes are 0.
- resp_count  out  3  bytes actually received.
- resp_valid  out  1  one-cycle pulse at end of transaction.
- timeout  out  1  one-cycle pulse coincident with resp_valid when the response was cut short.
- frame_err  out  1  sticky; set on a low stop bit, cleared on the next command accept.

Behaviour:
- Reset (extReset low, async): tx=1, cmd_ready=1, busy=0, resp_data=0, resp_count=0, resp_valid=0, timeout=0, frame_err=0, state IDLE.
- Accept: when cmd_valid && cmd_ready, latch cmd and resp_len, clear resp_data, resp_count and frame_err. tx goes low (start bit) on the next cycle.
- Frame length: opcode[7]=1 → 5 bytes, else 1 byte.
- Byte order: opcode, data[7:0], data[15:8], data[23:16], data[31:24].
- UART frame: start(0), 8 data bits LSB first, stop(1); each bit held exactly BITLENGTH cycles.
- Next byte's start bit immediately follows the previous stop bit, with no extra idle.
- TX FSM: IDLE → TX_START → TX_DATA (bit counter 0..7) → TX_STOP → TX_START again if bytes remain, else RX_WAIT.
- If resp_len=0, skip RX_WAIT and go straight to DONE after the last stop bit.
- RX_WAIT:
  - Timeout counter loads TIMEOUT_BITS*BITLENGTH on entry and reloads after each received byte.
  - A falling edge on synchronized rx → RX_START.
  - Counter reaching 0 → DONE with timeout=1.
- RX_START: wait BITLENGTH/2 cycles and resample. If still low, go to RX_DATA; if high, treat as a glitch and return to RX_WAIT without reloading the timeout.
- RX_DATA: sample every BITLENGTH cycles, 8 bits LSB first, then RX_STOP.
- RX_STOP: sample the stop bit; low sets frame_err. The byte is stored regardless and resp_count increments.
  - If resp_count reaches resp_len → DONE.
  - Else → RX_WAIT, which reloads the timeout.
- DONE: single cycle; resp_valid=1 (timeout as determined), busy drops the next cycle, → IDLE.
- Extra device bytes after DONE are ignored.
- Latency: 1-byte command with resp_len=0 gives resp_valid 10*BITLENGTH+1 cycles after accept, ±1 cycle; the bench checks with that tolerance.
- cmd_valid while busy is ignored; the command is not queued.
- rx activity during the TX states is ignored.
- Reset mid-operation: immediate abort, tx forced high, no resp_valid.

Decomposition:
- Shared header sump_defs.vh: SUMP opcodes (RESET 00, RUN 01, QUERY_ID 02, QUERY_META 04, QUERY_INPUT 06), LONG_CMD bit index 7, FSM state encodings.
- One natural sub-module, sump_uart_rx_byte: start validation, bit sampling and stop check. Outputs a byte-valid strobe, the data byte and a stop-error flag.
- TX sequencing stays in the top module.

Test Plan:
(sim with FREQ=1000000, RATE=100000 → BITLENGTH=10)
- Reset cmd 0x00 with resp_len=0 → tx shows one frame with bits 0,00000000,1, 100 cycles total. resp_valid, resp_count=0, timeout=0.
- Long cmd opcode 0xC0, data 0x12345678 → tx bytes C0,78,56,34,12 back-to-back, 500 cycles with no idle gaps.
- QUERY_ID 0x02 with resp_len=4; device model replies 0x31,0x41,0x4C,0x53 → resp_data=0x534C4131, resp_count=4, timeout=0, frame_err=0.
- resp_len=4 with only 2 reply bytes (0xAA, 0x55) → timeout pulse 400 cycles after the second stop bit. resp_count=2, resp_data=0x000055AA.
- rx glitch low for 3 cycles in RX_WAIT → no byte counted. Reply byte with stop bit 0 → frame_err=1, byte stored; frame_err clears on the next accept.
- extReset asserted mid-TX_DATA → tx=1 within the same cycle, cmd_ready=1, no resp_valid. A new command then transmits correctly.

Source files
------------

// File: rtl/sump_host_link_pkg.sv
// Shared definitions for the SUMP host link: opcodes, long-command flag and FSM encodings.
package sump_host_link_pkg;

   localparam logic [7:0] OP_RESET       = 8'h00;
   localparam logic [7:0] OP_RUN         = 8'h01;
   localparam logic [7:0] OP_QUERY_ID    = 8'h02;
   localparam logic [7:0] OP_QUERY_META  = 8'h04;
   localparam logic [7:0] OP_QUERY_INPUT = 8'h06;

   // Opcodes with this bit set carry four data bytes after the opcode.
   localparam int LONG_CMD_BIT = 7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TX_START,
      S_TX_DATA,
      S_TX_STOP,
      S_RX_WAIT,
      S_DONE
   } host_state_e;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

   function automatic logic [2:0] clamp_len(input logic [2:0] len);
      return (len > 3'd4) ? 3'd4 : len;
   endfunction

endpackage

// File: rtl/sump_uart_rx_byte.sv
// UART byte receiver: validates the start bit at mid-bit, samples 8 data bits LSB first,
// checks the stop bit. Held idle (and blind to rx edges) while en_i is low.
module sump_uart_rx_byte
   import sump_host_link_pkg::*;
#(
   parameter int BITLENGTH = 10
) (
   input  logic       clock,
   input  logic       extReset,
   input  logic       en_i,
   input  logic       rx_i,
   output logic       active_o,
   output logic       byte_vld_o,
   output logic [7:0] byte_o,
   output logic       stop_err_o
);

   localparam int CW   = $clog2(BITLENGTH + 1);
   localparam int HALF = (BITLENGTH / 2 > 0) ? BITLENGTH / 2 : 1;

   logic [1:0]    sync_q;
   logic          prev_q;
   logic          rx_s;
   rx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;

   assign rx_s = sync_q[1];

   always_ff @(posedge clock or negedge extReset) begin
      if (!extReset) begin
         sync_q  <= 2'b11;
         prev_q  <= 1'b1;
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
      end else begin
         sync_q  <= {sync_q[0], rx_i};
         prev_q  <= rx_s;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      sh_d       = sh_q;
      byte_vld_o = 1'b0;
      stop_err_o = 1'b0;
      if (!en_i) begin
         state_d = RX_IDLE;
      end else begin
         case (state_q)
            RX_IDLE: begin
               if (prev_q && !rx_s) begin
                  state_d = RX_START;
                  cnt_d   = CW'(HALF - 1);
               end
            end
            RX_START: begin
               // A start bit that is high again at mid-bit was only a glitch.
               if (cnt_q == '0) begin
                  if (!rx_s) begin
                     state_d = RX_DATA;
                     cnt_d   = CW'(BITLENGTH - 1);
                     bit_d   = '0;
                  end else begin
                     state_d = RX_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            RX_DATA: begin
               if (cnt_q == '0) begin
                  sh_d  = {rx_s, sh_q[7:1]};
                  cnt_d = CW'(BITLENGTH - 1);
                  if (bit_q == 3'd7) state_d = RX_STOP;
                  else               bit_d   = bit_q + 3'd1;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            RX_STOP: begin
               if (cnt_q == '0) begin
                  byte_vld_o = 1'b1;
                  stop_err_o = !rx_s;
                  state_d    = RX_IDLE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: state_d = RX_IDLE;
         endcase
      end
   end

   assign active_o = (state_q != RX_IDLE);
   assign byte_o   = sh_q;

endmodule

// File: rtl/sump_host_link.sv
// SUMP host link: sends a 1- or 5-byte command as back-to-back UART frames on tx,
// then gathers up to four little-endian response bytes from rx with an idle timeout.
module sump_host_link
   import sump_host_link_pkg::*;
#(
   parameter int FREQ         = 100000000,
   parameter int RATE         = 115200,
   parameter int TIMEOUT_BITS = 40
) (
   input  logic        clock,
   input  logic        extReset,
   input  logic [39:0] cmd,
   input  logic        cmd_valid,
   input  logic [2:0]  resp_len,
   output logic        cmd_ready,
   output logic        busy,
   output logic        tx,
   input  logic        rx,
   output logic [31:0] resp_data,
   output logic [2:0]  resp_count,
   output logic        resp_valid,
   output logic        timeout,
   output logic        frame_err
);

   localparam int BITLENGTH = FREQ / RATE;
   localparam int TO_CYC    = TIMEOUT_BITS * BITLENGTH;
   localparam int CW        = $clog2(BITLENGTH + 1);
   localparam int TW        = $clog2(TO_CYC + 1);

   host_state_e   state_q, state_d;
   logic [39:0]   cmd_q, cmd_d;
   logic [2:0]    len_q, len_d, idx_q, idx_d, bit_q, bit_d, count_q, count_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] to_q, to_d;
   logic [31:0]   data_q, data_d;
   logic          ferr_q, ferr_d, tout_q, tout_d;
   logic          rx_en, rx_active, rx_vld, rx_err;
   logic [7:0]    rx_byte, tx_byte;
   logic          cnt_zero, last_byte;

   assign cnt_zero  = (cnt_q == '0);
   assign last_byte = cmd_q[LONG_CMD_BIT] ? (idx_q == 3'd4) : 1'b1;
   assign rx_en     = (state_q == S_RX_WAIT);

   always_comb begin
      case (idx_q)
         3'd1:    tx_byte = cmd_q[15:8];
         3'd2:    tx_byte = cmd_q[23:16];
         3'd3:    tx_byte = cmd_q[31:24];
         3'd4:    tx_byte = cmd_q[39:32];
         default: tx_byte = cmd_q[7:0];
      endcase
   end

   sump_uart_rx_byte #(.BITLENGTH(BITLENGTH)) u_rx (
      .clock      (clock),
      .extReset   (extReset),
      .en_i       (rx_en),
      .rx_i       (rx),
      .active_o   (rx_active),
      .byte_vld_o (rx_vld),
      .byte_o     (rx_byte),
      .stop_err_o (rx_err)
   );

   always_ff @(posedge clock or negedge extReset) begin
      if (!extReset) begin
         state_q <= S_IDLE;
         cmd_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         bit_q   <= '0;
         count_q <= '0;
         cnt_q   <= '0;
         to_q    <= '0;
         data_q  <= '0;
         ferr_q  <= 1'b0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         bit_q   <= bit_d;
         count_q <= count_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
         data_q  <= data_d;
         ferr_q  <= ferr_d;
         tout_q  <= tout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      len_d   = len_q;
      idx_d   = idx_q;
      bit_d   = bit_q;
      count_d = count_q;
      cnt_d   = cnt_q;
      to_d    = to_q;
      data_d  = data_q;
      ferr_d  = ferr_q;
      tout_d  = tout_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               state_d = S_TX_START;
               cmd_d   = cmd;
               len_d   = clamp_len(resp_len);
               idx_d   = '0;
               cnt_d   = CW'(BITLENGTH - 1);
               data_d  = '0;
               count_d = '0;
               ferr_d  = 1'b0;
               tout_d  = 1'b0;
            end
         end
         S_TX_START: begin
            if (cnt_zero) begin
               state_d = S_TX_DATA;
               cnt_d   = CW'(BITLENGTH - 1);
               bit_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_TX_DATA: begin
            if (cnt_zero) begin
               cnt_d = CW'(BITLENGTH - 1);
               if (bit_q == 3'd7) state_d = S_TX_STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_TX_STOP: begin
            if (cnt_zero) begin
               if (!last_byte) begin
                  state_d = S_TX_START;
                  idx_d   = idx_q + 3'd1;
                  cnt_d   = CW'(BITLENGTH - 1);
               end else if (len_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RX_WAIT;
                  to_d    = TW'(TO_CYC);
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RX_WAIT: begin
            // The timeout only runs while no byte is in flight; a rejected glitch resumes it unreloaded.
            if (rx_vld) begin
               data_d[{count_q[1:0], 3'b000} +: 8] = rx_byte;
               count_d = count_q + 3'd1;
               if (rx_err) ferr_d = 1'b1;
               if (count_q + 3'd1 == len_q) state_d = S_DONE;
               else                         to_d    = TW'(TO_CYC);
            end else if (!rx_active) begin
               if (to_q == '0) begin
                  state_d = S_DONE;
                  tout_d  = 1'b1;
               end else begin
                  to_d = to_q - 1'b1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      case (state_q)
         S_TX_START: tx = 1'b0;
         S_TX_DATA:  tx = tx_byte[bit_q];
         default:    tx = 1'b1;
      endcase
   end

   assign cmd_ready  = (state_q == S_IDLE);
   assign busy       = !cmd_ready;
   assign resp_valid = (state_q == S_DONE);
   assign timeout    = resp_valid & tout_q;
   assign resp_data  = data_q;
   assign resp_count = count_q;
   assign frame_err  = ferr_q;

endmodule
